// File: rtl/dds_meas_pkg.sv
// Shared types and constants for the DDS frequency meter: FSM and comparator
// state encodings plus the waveform sample width.
package dds_meas_pkg;

  localparam int unsigned SAMPLE_W = 14;
  localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DONE    = 2'd2
  } meas_state_e;

  typedef enum logic [1:0] {
    CMP_UNKNOWN = 2'd0,
    CMP_LOW     = 2'd1,
    CMP_HIGH    = 2'd2
  } cmp_state_e;

endpackage

// File: rtl/dds_xing_det.sv
// Hysteresis comparator with rising-crossing detect. rise_o is combinational so
// a crossing on the current sample is seen by the caller in the same cycle.
module dds_xing_det
  import dds_meas_pkg::*;
#(
  parameter int unsigned MID_LEVEL = 8192,
  parameter int unsigned HYST      = 256
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                valid_i,
  input  logic                clear_i,
  output logic                rise_o
);

  localparam int HI_TH = int'(MID_LEVEL) + int'(HYST);
  localparam int LO_TH = int'(MID_LEVEL) - int'(HYST);

  cmp_state_e cmp_q, cmp_d;
  logic       above, below;

  always_comb begin
    above  = valid_i && ($signed({18'd0, sample_i}) >= HI_TH);
    below  = valid_i && ($signed({18'd0, sample_i}) <= LO_TH);
    cmp_d  = cmp_q;
    if (clear_i)    cmp_d = CMP_UNKNOWN;
    else if (above) cmp_d = CMP_HIGH;
    else if (below) cmp_d = CMP_LOW;
    // UNKNOWN->HIGH is deliberately not a crossing
    rise_o = !clear_i && above && (cmp_q == CMP_LOW);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) cmp_q <= CMP_UNKNOWN;
    else          cmp_q <= cmp_d;
  end

endmodule

// File: rtl/dds_freq_meter.sv
// Gated crossing counter / period meter for DDS waveforms.
// Optional min/max amplitude tracking is built when DDS_FREQ_METER_AMPL_EN is defined.
module dds_freq_meter
  import dds_meas_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 1000000,
  parameter int unsigned MID_LEVEL   = 8192,
  parameter int unsigned HYST        = 256
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Start,
  input  logic [SAMPLE_W-1:0] Data_in,
  input  logic                Data_valid,
  output logic                Busy,
  output logic                Result_valid,
  output logic [31:0]         Cross_cnt,
  output logic [31:0]         Period_cnt,
  output logic [SAMPLE_W-1:0] Vmax,
  output logic [SAMPLE_W-1:0] Vmin,
  output logic                Overflow
);

  localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 1);

  meas_state_e state_q, state_d;
  logic [31:0] gate_q, gate_d;
  logic [31:0] cross_q, cross_d;
  logic [31:0] first_q, first_d;
  logic [31:0] period_q, period_d;
  logic        have_first_q, have_first_d;
  logic        ovf_q, ovf_d;
  logic [31:0] cross_o_q, period_o_q;
  logic        ovf_o_q;
  logic        entering, in_meas, last_gate, rise;

  assign entering  = (state_q == ST_IDLE) && Start;
  assign in_meas   = (state_q == ST_MEASURE);
  assign last_gate = (gate_q == GATE_LAST);

  dds_xing_det #(
    .MID_LEVEL (MID_LEVEL),
    .HYST      (HYST)
  ) u_xing (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .sample_i (Data_in),
    .valid_i  (Data_valid),
    .clear_i  (entering),
    .rise_o   (rise)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (Start) state_d = ST_MEASURE;
      ST_MEASURE: if (last_gate) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gate_d       = gate_q;
    cross_d      = cross_q;
    first_d      = first_q;
    period_d     = period_q;
    have_first_d = have_first_q;
    ovf_d        = ovf_q;
    if (entering) begin
      gate_d       = '0;
      cross_d      = '0;
      first_d      = '0;
      period_d     = '0;
      have_first_d = 1'b0;
      ovf_d        = 1'b0;
    end else if (in_meas) begin
      gate_d = gate_q + 32'd1;
      if (rise) begin
        if (cross_q == '1) ovf_d   = 1'b1;
        else               cross_d = cross_q + 32'd1;
        // Period is bounded by the gate length, so it cannot wrap
        if (have_first_q) begin
          period_d = gate_q - first_q;
        end else begin
          first_d      = gate_q;
          have_first_d = 1'b1;
        end
      end
    end
  end

  // Outputs load from the next-state values so the final window sample counts
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      gate_q       <= '0;
      cross_q      <= '0;
      first_q      <= '0;
      period_q     <= '0;
      have_first_q <= 1'b0;
      ovf_q        <= 1'b0;
      cross_o_q    <= '0;
      period_o_q   <= '0;
      ovf_o_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_q       <= gate_d;
      cross_q      <= cross_d;
      first_q      <= first_d;
      period_q     <= period_d;
      have_first_q <= have_first_d;
      ovf_q        <= ovf_d;
      if (in_meas && last_gate) begin
        cross_o_q  <= cross_d;
        period_o_q <= period_d;
        ovf_o_q    <= ovf_d;
      end
    end
  end

`ifdef DDS_FREQ_METER_AMPL_EN
  logic [SAMPLE_W-1:0] max_q, max_d, min_q, min_d;
  logic [SAMPLE_W-1:0] vmax_o_q, vmin_o_q;

  always_comb begin
    max_d = max_q;
    min_d = min_q;
    if (entering) begin
      max_d = '0;
      min_d = SAMPLE_MAX;
    end else if (in_meas && Data_valid) begin
      if (Data_in > max_q) max_d = Data_in;
      if (Data_in < min_q) min_d = Data_in;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      max_q    <= '0;
      min_q    <= SAMPLE_MAX;
      vmax_o_q <= '0;
      vmin_o_q <= '0;
    end else begin
      max_q <= max_d;
      min_q <= min_d;
      if (in_meas && last_gate) begin
        vmax_o_q <= max_d;
        vmin_o_q <= min_d;
      end
    end
  end

  assign Vmax = vmax_o_q;
  assign Vmin = vmin_o_q;
`else
  assign Vmax = '0;
  assign Vmin = '0;
`endif

  assign Busy         = in_meas;
  assign Result_valid = (state_q == ST_DONE);
  assign Cross_cnt    = cross_o_q;
  assign Period_cnt   = period_o_q;
  assign Overflow     = ovf_o_q;

endmodule

// File: doc/dds_freq_meter.md
DDS_FREQ_METER -- requirements
Module: dds_freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 1000000: measurement window length in Clk cycles, allowed range 2..2^32-1.
REQ-002 SHALL have parameter MID_LEVEL, default 8192: crossing threshold (unsigned offset-binary code).
REQ-003 SHALL have parameter HYST, default 256: hysteresis half-width in codes.
REQ-004 SHALL have port Clk  input  1  system clock; all logic rising-edge.
REQ-005 SHALL have port Reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Start  input  1  one-cycle measurement request.
REQ-007 SHALL have port Data_in  input  14  waveform sample, unsigned 0..16383, same coding as DDS Data output.
REQ-008 SHALL have port Data_valid  input  1  Data_in qualifier.
REQ-009 SHALL have port Busy  output  1  high while a measurement is armed or running.
REQ-010 SHALL have port Result_valid  output  1  one-cycle pulse when results update.
REQ-011 SHALL have port Cross_cnt  output  32  rising crossings counted in window.
REQ-012 SHALL have port Period_cnt  output  32  Clk cycles from first to last rising crossing.
REQ-013 SHALL have port Vmax  output  14  largest valid sample in window.
REQ-014 SHALL have port Vmin  output  14  smallest valid sample in window.
REQ-015 SHALL have port Overflow  output  1  Cross_cnt or Period_cnt saturated in last window.

Function
REQ-016 SHALL implement FSM IDLE -> MEASURE -> DONE -> IDLE; Start in IDLE enters MEASURE next cycle with Busy=1; Start in MEASURE or DONE ignored.
REQ-017 SHALL run a gate counter in MEASURE that advances every Clk regardless of Data_valid; after exactly GATE_CYCLES cycles in MEASURE the FSM enters DONE.
REQ-018 SHALL track comparator state UNKNOWN/LOW/HIGH, cleared to UNKNOWN on MEASURE entry: valid sample >= MID_LEVEL+HYST sets HIGH, <= MID_LEVEL-HYST sets LOW, otherwise state holds.
REQ-019 SHALL count a rising crossing only on LOW->HIGH; UNKNOWN->HIGH is not counted.
REQ-020 SHALL latch the gate-counter value at the first rising crossing and update Period_cnt working value as (current gate count - first) at each later crossing; Period_cnt = 0 if fewer than two crossings.
REQ-021 SHALL track min/max over valid samples in MEASURE; with no valid samples, Vmax=0 and Vmin=16383.
REQ-022 SHALL saturate counters at 2^32-1 and set Overflow for that window.
REQ-023 SHALL, in DONE (one cycle), copy working values to output registers and pulse Result_valid; Busy=0 in DONE; outputs hold until next DONE.
REQ-024 SHALL give Result_valid latency of GATE_CYCLES+1 cycles after the Start cycle.
REQ-025 SHALL treat an in-window crossing on the final MEASURE cycle as counted.

Reset
REQ-026 SHALL, on Reset_n low (any time, incl. mid-measurement), force FSM IDLE, Busy=0, Result_valid=0, Cross_cnt=0, Period_cnt=0, Vmax=0, Vmin=0, Overflow=0, discarding partial results.

Configuration
REQ-027 SHALL compile min/max tracking only when DDS_FREQ_METER_AMPL_EN is defined; undefined: no tracking logic, Vmax and Vmin constant 0, all other behaviour unchanged.

Structure
REQ-028 SHALL place FSM state encoding, comparator state encoding and the 14-bit sample width constant in shared package dds_meas_pkg.
REQ-029 SHALL implement the hysteresis comparator and rising-edge detect as sub-module dds_xing_det (inputs sample, valid, clear; output rise pulse).

Verification (GATE_CYCLES=1000, MID_LEVEL=8192, HYST=256, macro defined unless noted)
REQ-030 SHALL cover: square wave 0/16383, 10 cycles each, starting low, Start -> after 1001 cycles Result_valid, Cross_cnt=50, Period_cnt=980, Vmax=16383, Vmin=0, Overflow=0.
REQ-031 SHALL cover: samples alternating 8100/8300 each cycle -> Cross_cnt=0, Period_cnt=0, Vmax=8300, Vmin=8100.
REQ-032 SHALL cover: waveform starting at 16383 (UNKNOWN->HIGH) with one later LOW->HIGH -> Cross_cnt=1, Period_cnt=0.
REQ-033 SHALL cover: second Start 200 cycles into a measurement -> ignored, single Result_valid at cycle 1001.
REQ-034 SHALL cover: Reset_n low at cycle 500 of measurement -> all outputs 0, Busy=0, no Result_valid until a new Start.
REQ-035 SHALL cover: macro undefined, square wave of REQ-030 -> Cross_cnt=50, Vmax=0, Vmin=0.
